// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write arbiter
// Contents: arbiter state type, default parameter values, burst counter width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_BURST  = 4;

  // Burst counter needs to reach BURST-1; keep at least one bit so BURST=1 still elaborates.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req   in  N_REQ  request vector
//   last  in  OWN_W  previous owner; searched last (lowest priority)
//   pick  out OWN_W  first requester after last, modulo N_REQ
//   found out 1      any requester present
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int OWN_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OWN_W-1:0] last,
  output logic [OWN_W-1:0] pick,
  output logic             found
);

  logic [OWN_W-1:0] idx;

  // Walk last+1 .. last+N_REQ; the final step lands on last itself.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = OWN_W'((int'(last) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req         per-producer word-present flags
//   req_data    producer words, slice i at [i*DATA_W +: DATA_W]
//   fifo_full   FIFO full flag
//   ack         one-hot, producer word written at this edge
//   fifo_write  FIFO write strobe
//   fifo_data   FIFO write data
//   owner       current grant holder index
//   busy        high while a producer holds the grant
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = DEF_BURST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      fifo_full,
  output logic [N_REQ-1:0]          ack,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy
);

  localparam int OWN_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(N_REQ - 1);

  arb_state_t       state, state_n;
  logic [OWN_W-1:0] owner_q, owner_n;
  logic [OWN_W-1:0] last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             in_grant;
  logic             xfer;
  logic             release_now;
  logic [OWN_W-1:0] pick_last;
  logic [OWN_W-1:0] pick_idx;
  logic             pick_found;

  assign in_grant = (state == GRANT);

  // Outputs are purely combinational so a full FIFO blocks the write in the same cycle.
  assign xfer       = in_grant & req[owner_q] & ~fifo_full;
  assign fifo_write = xfer;
  assign ack        = xfer ? (N_REQ'(1) << owner_q) : '0;
  assign fifo_data  = in_grant ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
  assign owner      = owner_q;
  assign busy       = in_grant;

  // Release after the last word of a burst, or when the owner runs dry.
  assign release_now = in_grant & ((xfer & (cnt_q == CNT_LAST)) | ~req[owner_q]);

  // In IDLE the previous owner sets priority; on release the departing owner goes last.
  assign pick_last = in_grant ? owner_q : last_q;

  rr_pick #(
    .N_REQ (N_REQ),
    .OWN_W (OWN_W)
  ) u_pick (
    .req   (req),
    .last  (pick_last),
    .pick  (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_n = state;
    owner_n = owner_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          owner_n = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_n = owner_q;
          cnt_n  = '0;
          if (pick_found) begin
            owner_n = pick_idx;
          end else begin
            state_n = IDLE;
          end
        end else if (xfer) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  ack;
  logic          fifo_write;
  logic [DW-1:0] fifo_data;
  logic [1:0]    owner;
  logic          busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST(BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .ack        (ack),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Producer word queues and enables: req[i] = en[i] and data remaining.
  logic [DW-1:0] q [N][$];
  logic [N-1:0]  en = '0;

  // Reference model: priority list rotated so the departing owner is last.
  int  prio[$];
  int  m_owner = -1;
  int  m_disp  = 0;
  int  m_cnt   = 0;
  bit  m_valid = 0;

  // Outputs sampled during the last step.
  logic [N-1:0]  o_ack;
  logic          o_write;
  logic [DW-1:0] o_data;
  logic [1:0]    o_owner;
  logic          o_busy;

  function automatic int pick(input logic [N-1:0] r);
    foreach (prio[k]) if (r[prio[k]]) return prio[k];
    return -1;
  endfunction

  task automatic step(input bit r, input bit full);
    logic [N-1:0]  rv;
    bit            eb, ew, xfer, rel;
    logic [N-1:0]  eack;
    logic [DW-1:0] edata;
    int            p;
    @(negedge clk);
    rst       = r;
    fifo_full = full;
    for (int i = 0; i < N; i++) begin
      rv[i] = en[i] && (q[i].size() > 0);
      req_data[i*DW +: DW] = rv[i] ? q[i][0] : '0;
    end
    req = rv;
    #2;
    o_ack = ack; o_write = fifo_write; o_data = fifo_data; o_owner = owner; o_busy = busy;
    eb    = (m_owner >= 0);
    ew    = eb && rv[m_owner] && !full;
    eack  = ew ? N'(1 << m_owner) : '0;
    edata = eb ? req_data[m_owner*DW +: DW] : '0;
    if (!r || (m_valid && !eb)) begin
      check("busy",  32'(busy),       32'(eb));
      check("write", 32'(fifo_write), 32'(ew));
      check("ack",   32'(ack),        32'(eack));
      check("data",  32'(fifo_data),  32'(edata));
      check("owner", 32'(owner),      32'(m_disp));
    end
    @(posedge clk);
    if (r) begin
      m_owner = -1; m_disp = 0; m_cnt = 0; m_valid = 1;
      prio = {0, 1, 2, 3};
    end else if (m_owner < 0) begin
      p = pick(rv);
      if (p >= 0) begin m_owner = p; m_disp = p; m_cnt = 0; end
    end else begin
      xfer = rv[m_owner] && !full;
      if (xfer) void'(q[m_owner].pop_front());
      rel = (xfer && m_cnt == BURST - 1) || !rv[m_owner];
      if (rel) begin
        while (prio[N-1] != m_owner) prio.push_back(prio.pop_front());
        p = pick(rv);
        m_cnt = 0;
        if (p >= 0) begin m_owner = p; m_disp = p; end
        else m_owner = -1;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) q[i].delete();
    en = '0;
    step(1, 0);
    step(1, 0);
  endtask

  initial begin
    // Reset with all producers requesting.
    for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) q[i].push_back(DW'(16'h1000 * (i + 1) + k));
    en = 4'b1111;
    step(1, 0);
    step(1, 0);
    check("rst_write", 32'(o_write), 32'd0);
    check("rst_ack",   32'(o_ack),   32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check("rst_owner", 32'(o_owner), 32'd0);
    step(0, 0);
    check("post_rst_owner", 32'(o_owner), 32'd0);
    step(0, 0);
    check("post_rst_grant", 32'(o_ack), 32'b0001);

    // Single producer 2, three words.
    clear_all();
    q[2] = {16'hA001, 16'hA002, 16'hA003};
    en = 4'b0100;
    step(0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0);
      check("single_owner", 32'(o_owner), 32'd2);
      check("single_ack",   32'(o_ack),   32'b0100);
      check("single_data",  32'(o_data),  32'(16'hA001 + k));
    end
    step(0, 0);
    step(0, 0);
    check("single_idle", 32'(o_busy), 32'd0);

    // Fairness: all four continuously requesting.
    clear_all();
    for (int i = 0; i < N; i++) for (int k = 0; k < 20; k++) q[i].push_back(DW'(16'h100 * i + k));
    en = 4'b1111;
    step(0, 0);
    for (int k = 0; k < 20; k++) begin
      step(0, 0);
      check("fair_owner", 32'(o_owner), 32'((k / 4) % 4));
      check("fair_write", 32'(o_write), 32'd1);
      check("fair_ack",   32'(o_ack),   32'(1 << ((k / 4) % 4)));
    end

    // Full stall on producer 1 after its second word.
    clear_all();
    q[1] = {16'hB001, 16'hB002, 16'hB003, 16'hB004};
    en = 4'b0010;
    step(0, 0);
    step(0, 0);
    step(0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 1);
      check("stall_write", 32'(o_write), 32'd0);
      check("stall_ack",   32'(o_ack),   32'd0);
      check("stall_owner", 32'(o_owner), 32'd1);
    end
    for (int k = 0; k < 2; k++) begin
      step(0, 0);
      check("stall_resume", 32'(o_data), 32'(16'hB003 + k));
      check("stall_ack2",   32'(o_ack),  32'b0010);
    end
    step(0, 0);
    check("stall_done", 32'(o_write), 32'd0);

    // Early drop: producer 0 has one word, producer 3 waiting.
    clear_all();
    q[0] = {16'hC001};
    q[3] = {16'hD001, 16'hD002};
    en = 4'b1001;
    step(0, 0);
    step(0, 0);
    check("drop_first", 32'(o_ack), 32'b0001);
    step(0, 0);
    check("drop_dead", 32'(o_write), 32'd0);
    step(0, 0);
    check("drop_owner", 32'(o_owner), 32'd3);
    check("drop_ack",   32'(o_ack),   32'b1000);

    // Reset during producer 3's second word.
    clear_all();
    q[3] = {16'hE001, 16'hE002, 16'hE003, 16'hE004};
    q[1] = {16'hF001, 16'hF002};
    en = 4'b1000;
    step(0, 0);
    step(0, 0);
    en = 4'b1010;
    step(1, 0);
    step(0, 0);
    check("mrst_idle", 32'(o_busy), 32'd0);
    step(0, 0);
    check("mrst_owner", 32'(o_owner), 32'd1);
    check("mrst_ack",   32'(o_ack),   32'b0010);

    // Randomized traffic against the model.
    clear_all();
    en = 4'b1111;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) q[i].push_back(DW'($urandom));
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
      end
      step($urandom_range(0, 399) == 0, $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single-clock 16-bit synchronous FIFO among `N_REQ` producers.
- Grants one producer at a time for a bounded burst of up to `BURST` words.
- Drives the FIFO write strobe and data directly from the granted producer.
- Stalls on FIFO full and rotates ownership fairly.
- Sits between the producer blocks and the FIFO write port; the FIFO read side is untouched.

## Interface
Parameters:
- `N_REQ`, 4, number of producers (2..8)
- `DATA_W`, 16, word width; matches the FIFO data width
- `BURST`, 4, maximum words per grant (>= 1)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset; one clock, `rst` synchronous and active-high
- `req`  in  N_REQ  producer i has a word on its data slice
- `req_data`  in  N_REQ*DATA_W  producer words; slice i at bits [i*DATA_W +: DATA_W]
- `fifo_full`  in  1  FIFO full flag
- `ack`  out  N_REQ  one-hot; word of producer i is written at this clock edge
- `fifo_write`  out  1  FIFO write strobe
- `fifo_data`  out  DATA_W  FIFO write data
- `owner`  out  $clog2(N_REQ)  index of the current grant holder
- `busy`  out  1  high while in GRANT

## Operation
- States:
  - IDLE: no owner.
  - GRANT: `owner` holds the bus; `cnt` counts accepted words (width $clog2(BURST), minimum 1).
- Registers: `state`, `owner`, `last` (previous owner), `cnt`.
- Pick function: first i with `req[i]`=1, searching `last`+1, `last`+2, … modulo N_REQ. `last` itself has lowest priority.
- IDLE:
  - If any `req`: pick, load `owner`, clear `cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT transfer condition: `fifo_write` = `req[owner]` & !`fifo_full`.
  - `ack[owner]` = `fifo_write`; all other `ack` bits are 0.
  - `fifo_data` = slice `owner` of `req_data`.
- GRANT release occurs at an edge where either:
  - a transfer happens with `cnt` = BURST-1, or
  - `req[owner]` = 0 (no transfer that cycle).
- On release:
  - `last` <= `owner`.
  - Pick from the current `req` with `owner` as lowest priority.
  - If a producer is found: stay in GRANT with the new `owner`, `cnt` = 0.
  - Otherwise go to IDLE.
- Otherwise on a transfer: `cnt` <= `cnt`+1.
- `fifo_full` high: no transfer, `cnt` and `owner` hold. There is no timeout.
- Outputs in IDLE: `fifo_write`=0, `ack`=0, `fifo_data`=0, `busy`=0.
- Producer rules:
  - Hold `req_data` stable while `req` is high and unacked.
  - Present the next word in the cycle after an `ack`.
  - Drop `req` when there is no data left.
- Reset (including mid-burst): `state`=IDLE, `owner`=0, `last`=N_REQ-1, `cnt`=0. Producer 0 therefore has top priority after reset.

## Timing
- `req` rising in IDLE at cycle t: `busy`/`owner` valid at t+1; first `ack`/`fifo_write` at t+1 if not full.
- Back-to-back bursts: no bubble when release happens on a transfer and another producer is waiting.
- One idle cycle when release is caused by the owner dropping `req`.
- `fifo_write`, `ack` and `fifo_data` are combinational from registered state plus `req`/`fifo_full`/`req_data`. There are no registered outputs, so `fifo_full` feedback is exact and the FIFO can never be overwritten.
- Throughput: one word per cycle while the owner holds `req` and the FIFO is not full.

## Structure
- Package `fifo_arb_pkg`:
  - state typedef (IDLE, GRANT)
  - default `DATA_W`=16, `N_REQ`=4, `BURST`=4 constants
- Sub-module `rr_pick`, combinational:
  - inputs: `req` vector, `last` index
  - outputs: picked index, `found`
  - used at both IDLE entry and release.
- Top: state/`owner`/`last`/`cnt` registers plus output muxing, 150-250 lines.

## Test plan
- Reset: `rst`=1 for 2 cycles with `req`=4'b1111 → `fifo_write`=0, `ack`=0, `busy`=0, `owner`=0. First cycle after reset: `owner`=0.
- Single producer: `req`[2] high with words 0xA001, 0xA002, 0xA003, then dropped; `fifo_full`=0.
  - Expect `owner`=2 one cycle after `req` rises.
  - `ack`=4'b0100 for 3 consecutive cycles, with `fifo_data` 0xA001→0xA003.
  - Then IDLE, `busy`=0.
- Fairness: all four `req` held continuously, `BURST`=4.
  - Grant order 0,1,2,3,0, each exactly 4 `ack`s.
  - `fifo_write` high every cycle, with no gaps between bursts.
- Full stall: `fifo_full`=1 for 3 cycles after producer 1's 2nd word.
  - `fifo_write`=0, `ack`=0, `owner`=1 held.
  - After `fifo_full` drops, words 3 and 4 are acked, then ownership moves on.
- Early drop: producer 0 drops `req` after 1 word while `req`[3]=1.
  - 1 dead cycle, then `owner`=3, `ack`=4'b1000.
- Reset mid-burst: `rst` during producer 3's 2nd word with `req`[1] and `req`[3] high.
  - Next cycle IDLE.
  - After `rst` drops, producer 1 is granted first.
